// File: rtl/regfile_pkg.sv
// Shared constants and byte-lane merge helper for the register file.
// Used by both the storage write path and the optional read bypass.
package regfile_pkg;

    localparam int BYTE_W = 8;
    localparam int MAX_W  = 256;
    localparam int MAX_BE = MAX_W / BYTE_W;

    // Take new bytes where the enable is set, keep the old bytes elsewhere.
    // Callers zero-extend their operands to MAX_W and truncate the result.
    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0]  old_v,
        input logic [MAX_W-1:0]  new_v,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_W-1:0] res;
        res = old_v;
        for (int i = 0; i < MAX_BE; i++) begin
            if (be[i]) begin
                res[i*BYTE_W +: BYTE_W] = new_v[i*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/register_nbit.sv
// One WIDTH-bit register: synchronous active-high reset, write enable,
// and per-byte enables.
module register_nbit
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [WIDTH/8-1:0] be,
    input  logic [WIDTH-1:0]   d,
    output logic [WIDTH-1:0]   q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next value: merged bytes on a write, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (we) begin
            data_d = WIDTH'(byte_merge(MAX_W'(data_q), MAX_W'(d),
                                       MAX_BE'(be)));
        end
    end

    // State register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/regfile_nbit.sv
// Register file with byte-enable writes and a busy scoreboard.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_nbit
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 16,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               regWrite,
    input  logic [ADDR_W-1:0]  wrAddr,
    input  logic [WIDTH-1:0]   wrData,
    input  logic [WIDTH/8-1:0] wrByteEn,
    input  logic               busySet,
    input  logic [ADDR_W-1:0]  busySetAddr,
    input  logic [ADDR_W-1:0]  rdAddrA,
    input  logic [ADDR_W-1:0]  rdAddrB,
    output logic [WIDTH-1:0]   rdDataA,
    output logic [WIDTH-1:0]   rdDataB,
    output logic               busyA,
    output logic               busyB
);

    logic [WIDTH-1:0]    entry [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (ZERO_REG != 0 && i == 0) begin : g_zero
            assign entry[i] = '0;
        end else begin : g_store
            register_nbit #(.WIDTH(WIDTH)) u_reg (
                .clk   (clk),
                .reset (reset),
                .we    (regWrite && wrAddr == ADDR_W'(i)),
                .be    (wrByteEn),
                .d     (wrData),
                .q     (entry[i])
            );
        end
    end

    // Scoreboard update: write clears, issue sets, set wins on a tie.
    always_comb begin
        busy_d = busy_q;
        if (regWrite) busy_d[wrAddr] = 1'b0;
        if (busySet)  busy_d[busySetAddr] = 1'b1;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    // Scoreboard register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

`ifdef REGFILE_BYPASS_EN
    logic hit_a;
    logic hit_b;

    // Read muxes with forwarding of the in-flight write.
    always_comb begin
        hit_a = regWrite && wrAddr == rdAddrA &&
                !(ZERO_REG != 0 && rdAddrA == '0);
        hit_b = regWrite && wrAddr == rdAddrB &&
                !(ZERO_REG != 0 && rdAddrB == '0);
        rdDataA = entry[rdAddrA];
        rdDataB = entry[rdAddrB];
        busyA   = busy_q[rdAddrA];
        busyB   = busy_q[rdAddrB];
        if (hit_a) begin
            rdDataA = WIDTH'(byte_merge(MAX_W'(entry[rdAddrA]),
                                        MAX_W'(wrData),
                                        MAX_BE'(wrByteEn)));
            busyA   = busySet && busySetAddr == rdAddrA;
        end
        if (hit_b) begin
            rdDataB = WIDTH'(byte_merge(MAX_W'(entry[rdAddrB]),
                                        MAX_W'(wrData),
                                        MAX_BE'(wrByteEn)));
            busyB   = busySet && busySetAddr == rdAddrB;
        end
    end
`else
    // Plain read muxes showing the stored state.
    always_comb begin
        rdDataA = entry[rdAddrA];
        rdDataB = entry[rdAddrB];
        busyA   = busy_q[rdAddrA];
        busyB   = busy_q[rdAddrB];
    end
`endif

endmodule

// File: tb/tb_regfile_nbit.sv
// Directed bench for regfile_nbit (WIDTH=32, NUM_REGS=16, ZERO_REG=1).
// Expected values are hand-computed constants.
module tb_regfile_nbit;

    logic        clk = 1'b0;
    logic        reset;
    logic        regWrite;
    logic [3:0]  wrAddr;
    logic [31:0] wrData;
    logic [3:0]  wrByteEn;
    logic        busySet;
    logic [3:0]  busySetAddr;
    logic [3:0]  rdAddrA;
    logic [3:0]  rdAddrB;
    logic [31:0] rdDataA;
    logic [31:0] rdDataB;
    logic        busyA;
    logic        busyB;

    int passed = 0;
    int total  = 0;

    regfile_nbit dut (
        .clk         (clk),
        .reset       (reset),
        .regWrite    (regWrite),
        .wrAddr      (wrAddr),
        .wrData      (wrData),
        .wrByteEn    (wrByteEn),
        .busySet     (busySet),
        .busySetAddr (busySetAddr),
        .rdAddrA     (rdAddrA),
        .rdAddrB     (rdAddrB),
        .rdDataA     (rdDataA),
        .rdDataB     (rdDataB),
        .busyA       (busyA),
        .busyB       (busyB)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset    = 1'b0;
        regWrite = 1'b0;
        busySet  = 1'b0;
        wrByteEn = 4'h0;
    endtask

    initial begin
        idle();
        wrAddr = 0; wrData = 0; busySetAddr = 0;
        rdAddrA = 0; rdAddrB = 0;
        #2;
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Reset state on every entry, both ports.
        for (int i = 0; i < 16; i++) begin
            rdAddrA = 4'(i);
            rdAddrB = 4'(15 - i);
            #1;
            check($sformatf("rst_dataA_%0d", i), rdDataA, 32'h0);
            check($sformatf("rst_dataB_%0d", i), rdDataB, 32'h0);
            check($sformatf("rst_busyA_%0d", i), 32'(busyA), 32'h0);
            check($sformatf("rst_busyB_%0d", i), 32'(busyB), 32'h0);
        end

        // Full write then low-byte write to r3.
        regWrite = 1; wrAddr = 3; wrData = 32'hDEADBEEF; wrByteEn = 4'hF;
        tick();
        wrData = 32'h000000AA; wrByteEn = 4'h1;
        tick();
        idle();
        rdAddrA = 3; rdAddrB = 3;
        #1;
        check("r3_merge_A", rdDataA, 32'hDEADBEAA);
        check("r3_merge_B", rdDataB, 32'hDEADBEAA);

        // Upper two bytes only.
        regWrite = 1; wrAddr = 3; wrData = 32'h1234FFFF; wrByteEn = 4'hC;
        tick();
        idle();
        #1;
        check("r3_upper", rdDataA, 32'h1234BEAA);

        // Busy set, then write+set tie, then write only.
        busySet = 1; busySetAddr = 5;
        tick();
        idle();
        rdAddrA = 5;
        #1;
        check("r5_busy_set", 32'(busyA), 32'h1);
        regWrite = 1; wrAddr = 5; wrData = 32'h11; wrByteEn = 4'hF;
        busySet = 1; busySetAddr = 5;
        tick();
        idle();
        #1;
        check("r5_tie_busy", 32'(busyA), 32'h1);
        check("r5_tie_data", rdDataA, 32'h11);
        regWrite = 1; wrAddr = 5; wrData = 32'h22; wrByteEn = 4'hF;
        tick();
        idle();
        #1;
        check("r5_clr_busy", 32'(busyA), 32'h0);
        check("r5_clr_data", rdDataA, 32'h22);

        // Empty byte enables still clear busy, data holds.
        busySet = 1; busySetAddr = 3;
        tick();
        idle();
        rdAddrB = 3;
        #1;
        check("r3_busy", 32'(busyB), 32'h1);
        regWrite = 1; wrAddr = 3; wrData = 32'hFFFFFFFF; wrByteEn = 4'h0;
        tick();
        idle();
        #1;
        check("r3_be0_data", rdDataB, 32'h1234BEAA);
        check("r3_be0_busy", 32'(busyB), 32'h0);

        // Write to a non-busy register.
        regWrite = 1; wrAddr = 9; wrData = 32'hCAFEF00D; wrByteEn = 4'hF;
        tick();
        idle();
        rdAddrA = 9;
        #1;
        check("r9_data", rdDataA, 32'hCAFEF00D);
        check("r9_busy", 32'(busyA), 32'h0);

        // Zero register ignores writes and busy set.
        rdAddrA = 0; rdAddrB = 0;
        regWrite = 1; wrAddr = 0; wrData = 32'h12345678; wrByteEn = 4'hF;
        busySet = 1; busySetAddr = 0;
        #1;
        check("r0_same_cycle", rdDataB, 32'h0);
        tick();
        idle();
        #1;
        check("r0_data", rdDataA, 32'h0);
        check("r0_busy", 32'(busyA), 32'h0);

        // Same-cycle read of an in-flight write to r7 (busy beforehand).
        busySet = 1; busySetAddr = 7;
        tick();
        idle();
        rdAddrB = 7;
        regWrite = 1; wrAddr = 7; wrData = 32'h0000FFFF; wrByteEn = 4'hF;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("r7_bypass_data", rdDataB, 32'h0000FFFF);
        check("r7_bypass_busy", 32'(busyB), 32'h0);
`else
        check("r7_old_data", rdDataB, 32'h0);
        check("r7_old_busy", 32'(busyB), 32'h1);
`endif
        tick();
        idle();
        #1;
        check("r7_after_edge", rdDataB, 32'h0000FFFF);
        check("r7_busy_after", 32'(busyB), 32'h0);

        // Reset mid-sequence wipes data and busy, beating write/set.
        regWrite = 1; wrAddr = 2; wrData = 32'h55; wrByteEn = 4'hF;
        busySet = 1; busySetAddr = 2;
        tick();
        idle();
        rdAddrA = 2;
        #1;
        check("r2_pre_data", rdDataA, 32'h55);
        check("r2_pre_busy", 32'(busyA), 32'h1);
        reset = 1;
        regWrite = 1; wrAddr = 2; wrData = 32'hFF; wrByteEn = 4'hF;
        busySet = 1; busySetAddr = 2;
        tick();
        idle();
        #1;
        check("r2_rst_data", rdDataA, 32'h0);
        check("r2_rst_busy", 32'(busyA), 32'h0);
        rdAddrB = 9;
        #1;
        check("r9_rst_data", rdDataB, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
